// File: rtl/rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer: the sequencer state encoding,
// the default parameter values and a helper that sizes the shared
// stretch/stagger down-counter.
// ----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_STRETCH_CYCLES = 8;
    localparam int DEFAULT_STAGGER_CYCLES = 4;
    localparam int DEFAULT_NUM_OUT        = 3;

    // One counter serves both the stretch and the stagger phases, so it is
    // sized for the larger of the two. It holds at most (max - 1), which
    // $clog2(max) bits cover; a 1-bit floor keeps the vector legal.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if ($clog2(m) < 1) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/rst_seq_rst_sync.sv
// ----------------------------------------------------------------------------
// rst_sync
// Reset synchronizer. Asserts its output asynchronously with rst and
// releases it synchronously, STAGES rising edges after rst falls.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   rst_s_o out  synchronized reset (1 = in reset)
// ----------------------------------------------------------------------------
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_s_o
);

    logic [STAGES-1:0] sync_q;

    // Ones are preloaded by rst; zeros shift in from stage 0 once rst drops,
    // so the last stage falls on the STAGES-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// ----------------------------------------------------------------------------
// rst_seq
// Reset sequencer. After the synchronized release of rst, all domain resets
// are held for STRETCH_CYCLES (longer while hold_i is high), then released
// one domain at a time in ascending order, STAGGER_CYCLES apart. ready_o
// rises once every domain is out of reset. sw_rst_i restarts the sequence
// from the stretch phase.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   sw_rst_i  in   synchronous software reset request (1-cycle pulse)
//   hold_i    in   keep all domains in reset before release begins
//   rst_o     out  per-domain active-high resets, straight from flops
//   ready_o   out  all domains released
// ----------------------------------------------------------------------------
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int STAGGER_CYCLES = DEFAULT_STAGGER_CYCLES,
    parameter int NUM_OUT        = DEFAULT_NUM_OUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_i,
    input  logic               hold_i,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               ready_o
);

    localparam int CNT_W = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

    // After the final domain is released the counter is loaded with zero,
    // so DONE follows on the very next edge instead of a full stagger later.
    localparam logic [CNT_W-1:0] FIRST_LOAD = (NUM_OUT == 1) ? '0 : STAGGER_LOAD;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             rst_s;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_s_o (rst_s)
    );

    // Sequencer. idx names the next domain to release; rst_o and ready_o are
    // registered here so the outputs carry no combinational logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_o   <= '1;
            ready_o <= 1'b0;
        end else if (state == ASSERT) begin
            if (!rst_s) begin
                state <= STRETCH;
                cnt   <= STRETCH_LOAD;
            end
        end else if (sw_rst_i) begin
            // Software reset outranks any release due on this edge.
            state   <= STRETCH;
            cnt     <= STRETCH_LOAD;
            idx     <= '0;
            rst_o   <= '1;
            ready_o <= 1'b0;
        end else begin
            case (state)
                STRETCH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!hold_i) begin
                        state    <= RELEASE;
                        rst_o[0] <= 1'b0;
                        idx      <= IDX_W'(1);
                        cnt      <= FIRST_LOAD;
                    end
                end
                RELEASE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (idx == IDX_W'(NUM_OUT)) begin
                        state   <= DONE;
                        ready_o <= 1'b1;
                    end else begin
                        for (int i = 1; i < NUM_OUT; i++) begin
                            if (idx == IDX_W'(i)) begin
                                rst_o[i] <= 1'b0;
                            end
                        end
                        idx <= idx + IDX_W'(1);
                        cnt <= (idx == IDX_W'(NUM_OUT - 1)) ? '0 : STAGGER_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: reset synchronizer depth; legal values >= 2.
REQ-002 SHALL provide parameter STRETCH_CYCLES, default 8: minimum reset hold after synchronized release; legal values >= 1.
REQ-003 SHALL provide parameter STAGGER_CYCLES, default 4: spacing between successive domain releases; legal values >= 1.
REQ-004 SHALL provide parameter NUM_OUT, default 3: number of reset domains; legal values 1..16.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 sw_rst_i  input  1  synchronous software reset request; a 1-cycle pulse is sufficient.
REQ-008 hold_i  input  1  synchronous request to keep all domains in reset before release begins.
REQ-009 rst_o  output  NUM_OUT  per-domain reset; active-high, asserted asynchronously, released synchronously to clk.
REQ-010 ready_o  output  1  high when all domains are released.

Function
REQ-011 States SHALL be ASSERT, STRETCH, RELEASE and DONE.
REQ-012 rst high SHALL force state ASSERT, all rst_o bits = 1 and ready_o = 0 immediately, without waiting for a clk edge.
REQ-013 rst deassertion SHALL pass through a SYNC_STAGES-flop synchronizer that resets to 1; its output rst_s SHALL fall on the SYNC_STAGES-th rising edge after rst falls.
REQ-014 In ASSERT, the first edge with rst_s = 0 SHALL move to STRETCH and load counter = STRETCH_CYCLES-1.
REQ-015 In STRETCH, the counter SHALL decrement by 1 per edge while nonzero.
REQ-016 In STRETCH at counter 0 with hold_i = 1, the FSM SHALL stay in STRETCH with counter 0.
REQ-017 In STRETCH at counter 0 with hold_i = 0, the FSM SHALL move to RELEASE, clear rst_o[0] on that edge, set index = 1 and load counter = STAGGER_CYCLES-1.
REQ-018 In RELEASE, the counter SHALL decrement by 1 per edge while nonzero.
REQ-019 In RELEASE at counter 0, the FSM SHALL clear rst_o[index], increment index and reload the counter.
REQ-020 Releases SHALL proceed in ascending index order; a released bit SHALL stay 0 until a reset event.
REQ-021 hold_i SHALL be ignored in RELEASE and DONE.
REQ-022 On the first edge at counter 0 after rst_o[NUM_OUT-1] clears, the FSM SHALL enter DONE.
REQ-023 ready_o SHALL be registered: it rises one edge after rst_o[NUM_OUT-1] clears and is 1 only in DONE.
REQ-024 When NUM_OUT = 1, the FSM SHALL enter DONE on the edge after rst_o[0] clears.
REQ-025 sw_rst_i = 1 in STRETCH, RELEASE or DONE SHALL, on that edge:
  - set all rst_o to 1 and ready_o to 0;
  - enter STRETCH with counter = STRETCH_CYCLES-1.
REQ-026 sw_rst_i SHALL be ignored in ASSERT.
REQ-027 sw_rst_i SHALL take priority over a release scheduled for the same edge.
REQ-028 rst SHALL take priority over all other inputs.
REQ-029 rst asserted mid-sequence SHALL abort the sequence immediately and restart from ASSERT.
REQ-030 rst_o SHALL be driven directly from flops, with no combinational logic on the output path.

Reset
REQ-031 Under rst: state = ASSERT, counter = 0, index = 0, rst_o = all ones, ready_o = 0, synchronizer flops = 1.
REQ-032 All flops SHALL use the asynchronous active-high rst only; sw_rst_i SHALL never act asynchronously.

Structure
REQ-033 Package rst_seq_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-034 The synchronizer SHALL be a separate sub-module rst_sync (parameter STAGES; ports clk, rst, rst_s_o) with asynchronous assert and synchronous deassert.
REQ-035 The counter width SHALL be $clog2 of the larger of STRETCH_CYCLES and STAGGER_CYCLES, minimum 1.
REQ-036 The index width SHALL be $clog2(NUM_OUT+1).

Verification (default parameters; edge n = nth rising clk edge after rst falls mid-cycle)
REQ-037 Power-up: rst released -> rst_o = 3'b111 through edge 10; rst_o[0] falls at edge 11, [1] at 15, [2] at 19; ready_o = 1 at edge 20.
REQ-038 Hold: hold_i = 1 from edge 0 to edge 30 -> rst_o = 3'b111 until edge 31; rst_o[0] falls at edge 31, [1] at 35, [2] at 39.
REQ-039 Software reset in DONE: 1-cycle sw_rst_i at edge 25 -> rst_o = 3'b111 and ready_o = 0 after edge 25; rst_o[0] falls at edge 33.
REQ-040 Async abort: rst pulsed between edges 16 and 17 -> rst_o = 3'b111 and ready_o = 0 before edge 17 (mid-cycle); sequence restarts from ASSERT with release timing as in REQ-037.
REQ-041 Collision: sw_rst_i at edge 15 -> rst_o[1] stays 1 and the sequence restarts from STRETCH.
REQ-042 Checker: rst_o is monotonic-decreasing between reset events, and ready_o = 1 implies rst_o = 0.
